// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: scanout reads own every slot they ask for; queued
// writes and the clear sequencer share whatever slots are left.
module vram_port_arbiter #(
  parameter int                ADDR_W      = 11,
  parameter int                DATA_W      = 8,
  parameter int                WFIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL   = '0,
  parameter int                STARVE_MAX  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_starved,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] clr_ptr_reg;
  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [SC_W-1:0]   starve_cnt_reg;
  logic              starved_reg;
  logic              rd_pipe_reg;
  logic              rd_valid_reg;
  logic              clr_done_reg;
  logic              ram_ce_reg;
  logic              ram_we_reg;
  logic [ADDR_W-1:0] ram_ad_reg;
  logic [DATA_W-1:0] ram_din_reg;

  logic fifo_full, fifo_empty, push, pop, clr_slot, clr_last;

  assign fifo_full  = (count_reg == CNT_W'(WFIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign wr_ready   = !fifo_full && (state_reg == ST_IDLE);
  assign push       = wr_valid && wr_ready;
  // Reads pre-empt everything; the FIFO drains in IDLE and DRAIN only.
  assign pop        = !rd_req && !fifo_empty &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_DRAIN));
  assign clr_slot   = !rd_req && (state_reg == ST_CLEAR);
  assign clr_last   = clr_slot && (clr_ptr_reg == {ADDR_W{1'b1}});

  assign rd_valid   = rd_valid_reg;
  assign rd_data    = ram_dout;
  assign clr_busy   = (state_reg != ST_IDLE);
  assign clr_done   = clr_done_reg;
  assign wr_starved = starved_reg;
  assign ram_ce     = ram_ce_reg;
  assign ram_we     = ram_we_reg;
  assign ram_ad     = ram_ad_reg;
  assign ram_din    = ram_din_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail_reg] <= wr_addr;
      fifo_data[tail_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // RAM command register; address and data hold through idle slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_ce_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_ad_reg   <= '0;
      ram_din_reg  <= '0;
      rd_pipe_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      ram_ce_reg   <= rd_req || pop || clr_slot;
      ram_we_reg   <= pop || clr_slot;
      rd_pipe_reg  <= rd_req;
      rd_valid_reg <= rd_pipe_reg;
      if (rd_req) begin
        ram_ad_reg <= rd_addr;
      end else if (pop) begin
        ram_ad_reg  <= fifo_addr[head_reg];
        ram_din_reg <= fifo_data[head_reg];
      end else if (clr_slot) begin
        ram_ad_reg  <= clr_ptr_reg;
        ram_din_reg <= CLEAR_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      clr_ptr_reg  <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      clr_done_reg <= clr_last;
      case (state_reg)
        ST_IDLE:  if (clr_start) state_reg <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty) begin
          state_reg   <= ST_CLEAR;
          clr_ptr_reg <= '0;
        end
        ST_CLEAR: if (clr_slot) begin
          clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
          if (clr_last) state_reg <= ST_IDLE;
        end
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Counter saturates at STARVE_MAX; the flag is set on the cycle it gets there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      starved_reg    <= 1'b0;
    end else if (fifo_full) begin
      if (starve_cnt_reg != SC_W'(STARVE_MAX)) starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
      if (starve_cnt_reg == SC_W'(STARVE_MAX - 1)) starved_reg <= 1'b1;
    end else begin
      starve_cnt_reg <= '0;
    end
  end

endmodule
